// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding and unit-timing constants for the Morse controller
package morse_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ON, EGAP, CGAP, SPACE} state_t;
  localparam logic [1:0] DOT_UNITS  = 2'd1;
  localparam logic [1:0] DASH_UNITS = 2'd3;
  localparam logic [1:0] EGAP_UNITS = 2'd1;
  localparam logic [1:0] CGAP_UNITS = 2'd3;
  localparam logic [3:0] SPACE_LOAD = 4'd7;
endpackage

// File: rtl/morse_if.sv
// morse_if: character handshake plus code-register strobes between source, controller and register
interface morse_if;
  logic       char_valid;
  logic [3:0] charlen_data;
  logic       char_ready;
  logic [3:0] cntr_data;
  logic       shft_data;
  logic       char_load;
  logic       shft_cnt;
  modport master (
    output char_valid, charlen_data, cntr_data, shft_data,
    input  char_ready, char_load, shft_cnt
  );
  modport slave (
    input  char_valid, charlen_data, cntr_data, shft_data,
    output char_ready, char_load, shft_cnt
  );
endinterface

// File: rtl/morse_unit_timer.sv
// unit_timer: free-running 0..UNIT_CYCLES-1 counter, tick on the last count of each unit
module unit_timer #(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(UNIT_CYCLES);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(UNIT_CYCLES - 1);
  always_ff @(posedge clock)
    cnt <= (reset || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/morse_ctrl.sv
// morse_ctrl: sequences one character through the code register and keys it with Morse unit timing
module morse_ctrl
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000
) (
  input  logic clock,
  input  logic reset,
  morse_if.slave bus,
  output logic key_out,
  output logic busy
);
  state_t     state;
  logic       tick;
  logic       is_space;
  logic       elem_done;
  logic [1:0] dur;
  logic [1:0] units;
  logic [1:0] units_nx;
  unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );
  assign units_nx = units + 2'd1;
  // every output is forced low while reset is held, so an abort silences the key in that cycle
  always_comb begin
    elem_done      = tick && state == ON && units_nx == dur;
    bus.char_ready = !reset && state == IDLE;
    bus.char_load  = bus.char_ready && bus.char_valid;
    bus.shft_cnt   = !reset && (elem_done || (tick && state == SPACE));
    key_out        = !reset && state == ON;
    busy           = !reset && state != IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state    <= IDLE;
      is_space <= 1'b0;
      dur      <= DOT_UNITS;
      units    <= '0;
    end else
      case (state)
        IDLE:
          if (bus.char_valid) begin
            is_space <= bus.charlen_data == 4'd0;
            state    <= LOAD;
          end
        LOAD: state <= ALIGN;
        ALIGN:
          if (tick) begin
            state <= is_space ? SPACE : ON;
            dur   <= bus.shft_data ? DASH_UNITS : DOT_UNITS;
            units <= '0;
          end
        ON:
          if (tick) begin
            units <= elem_done ? '0 : units_nx;
            if (elem_done) state <= bus.cntr_data == 4'd1 ? CGAP : EGAP;
          end
        EGAP:
          if (tick) begin
            dur   <= bus.shft_data ? DASH_UNITS : DOT_UNITS;
            units <= '0;
            state <= ON;
          end
        CGAP:
          if (tick) begin
            units <= units_nx;
            if (units_nx == CGAP_UNITS) state <= IDLE;
          end
        SPACE:
          if (tick && bus.cntr_data == 4'd1) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_morse_ctrl.sv
// tb_morse_ctrl: directed checks of morse_ctrl keying with a behavioural code register
module tb_morse_ctrl;
  import morse_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_out;
  logic busy;
  logic [7:0] code;
  logic [7:0] sr;
  logic [3:0] cnt;
  int checks = 0;
  int errors = 0;
  int load_wait, lat, tot, extra, idle;
  int runs[$];
  int shft_at[$];
  morse_if bus();
  morse_ctrl #(.UNIT_CYCLES(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .key_out(key_out),
    .busy   (busy)
  );
  always #5 clock = ~clock;
  always_ff @(posedge clock)
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.char_load) begin
      sr  <= code;
      cnt <= bus.charlen_data == 4'd0 ? SPACE_LOAD : bus.charlen_data;
    end else if (bus.shft_cnt) begin
      sr  <= sr << 1;
      cnt <= cnt - 4'd1;
    end
  assign bus.cntr_data = cnt;
  assign bus.shft_data = sr[7];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic play(input logic [7:0] c, input logic [3:0] l, input bit hold,
                      input logic [7:0] nc, input logic [3:0] nl);
    bit k;
    int t;
    code = c;
    bus.charlen_data = l;
    bus.char_valid = 1'b1;
    #1;
    load_wait = 0;
    while (!bus.char_load && load_wait < 40) begin
      @(negedge clock);
      load_wait++;
    end
    runs.delete();
    shft_at.delete();
    lat = -1; extra = 0; idle = 0; k = 1'b0;
    @(posedge clock);
    #1;
    bus.char_valid = hold;
    code = nc;
    bus.charlen_data = nl;
    for (t = 1; t <= 200; t++) begin
      @(negedge clock);
      if (bus.char_ready) break;
      if (bus.char_load) extra++;
      if (!busy) idle++;
      if (bus.shft_cnt) shft_at.push_back(t);
      if (key_out && lat < 0) begin
        lat = t;
        k = 1'b1;
        runs.push_back(0);
      end
      if (lat >= 0) begin
        if (key_out != k) begin
          runs.push_back(0);
          k = key_out;
        end
        runs[runs.size()-1]++;
      end
    end
    tot = t;
  endtask
  task automatic verify(input string tag, input int elat, input int etot,
                        input int er[8], input int nr, input int es[8], input int ns);
    check({tag, ".load_wait"}, load_wait, 0);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".cycles"}, tot, etot);
    check({tag, ".extra_load"}, extra, 0);
    check({tag, ".not_busy"}, idle, 0);
    check({tag, ".nruns"}, runs.size(), nr);
    for (int i = 0; i < nr; i++)
      check($sformatf("%s.run%0d", tag, i), i < runs.size() ? runs[i] : -1, er[i]);
    check({tag, ".nshift"}, shft_at.size(), ns);
    for (int i = 0; i < ns; i++)
      check($sformatf("%s.shift%0d", tag, i), i < shft_at.size() ? shft_at[i] : -1, es[i]);
  endtask
  initial begin
    int n;
    code = 8'h00;
    bus.charlen_data = 4'd1;
    bus.char_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("reset.outs%0d", i),
            {bus.char_ready, bus.char_load, bus.shft_cnt, key_out, busy}, 0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check("reset.ready_after", bus.char_ready, 1);
    play(8'h00, 4'd1, 1'b0, 8'h00, 4'd0);
    verify("E", 4, 20, '{4, 12, 0, 0, 0, 0, 0, 0}, 2, '{7, 0, 0, 0, 0, 0, 0, 0}, 1);
    play(8'h40, 4'd2, 1'b0, 8'h00, 4'd0);
    verify("A", 4, 36, '{4, 4, 12, 12, 0, 0, 0, 0}, 4, '{7, 23, 0, 0, 0, 0, 0, 0}, 2);
    play(8'h00, 4'd0, 1'b0, 8'h00, 4'd0);
    verify("SPACE", -1, 32, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{7, 11, 15, 19, 23, 27, 31, 0}, 7);
    play(8'hE0, 4'd3, 1'b1, 8'h00, 4'd3);
    verify("O", 4, 60, '{12, 4, 12, 4, 12, 12, 0, 0}, 6, '{15, 31, 47, 0, 0, 0, 0, 0}, 3);
    play(8'h00, 4'd3, 1'b0, 8'h00, 4'd0);
    verify("S", 4, 36, '{4, 4, 4, 4, 4, 12, 0, 0}, 6, '{7, 15, 23, 0, 0, 0, 0, 0}, 3);
    code = 8'h80;
    bus.charlen_data = 4'd1;
    bus.char_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.char_load && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("T.load_wait", n, 0);
    @(posedge clock);
    #1 bus.char_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!key_out && n < 20);
    check("T.latency", n, 4);
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("T.key_d5", key_out, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("T.key_in_reset", key_out, 0);
    check("T.busy_in_reset", busy, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check("T.ready_after", bus.char_ready, 1);
    play(8'h00, 4'd1, 1'b0, 8'h00, 4'd0);
    verify("E2", 4, 20, '{4, 12, 0, 0, 0, 0, 0, 0}, 2, '{7, 0, 0, 0, 0, 0, 0, 0}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_ctrl.md
# morse_ctrl

Sequencing controller for the Morse encoder's code register (8-bit MSB-first code shifter plus 4-bit element down-counter). It accepts one character (code byte + length) per handshake and pulses `char_load` and `shft_cnt` into the code register. It converts the register's serial bits into a keyed output with standard unit timing: dot 1, dash 3, element gap 1, character gap 3. It sits between the character source (keyboard/ROM lookup) and the tone/LED driver, instantiated beside the code register in the encoder top.

## Interface
- `UNIT_CYCLES`, default 12_500_000: clock cycles per Morse time unit. Legal values are ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset. The same net also drives the code register's reset.
- `char_valid`  in  1  source has a character on `charlen_data` (and on the code bus to the code register).
- `charlen_data`  in  4  element count of the offered character, 0..8; 0 means word space.
- `char_ready`  out  1  controller can accept a character this cycle.
- `cntr_data`  in  4  code register counter value.
- `shft_data`  in  1  code register MSB (1 = dash, 0 = dot).
- `char_load`  out  1  one-cycle load strobe to the code register.
- `shft_cnt`  out  1  one-cycle shift/decrement strobe to the code register.
- `key_out`  out  1  key/tone enable.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Unit timer.** Free-running counter 0..UNIT_CYCLES-1; `tick`=1 in the cycle where count = UNIT_CYCLES-1. It wraps to 0 and runs in all states.
- **IDLE.** `char_ready`=1. When `char_valid` is high: assert `char_load` this cycle, latch `is_space` = (`charlen_data`==0), go to LOAD.
- **LOAD.** One cycle while the code register captures the character (for a space, the register loads counter value 7). Go to ALIGN.
- **ALIGN.** Wait for `tick`. On `tick`: go to SPACE if `is_space`, else go to ON. Latch `dur` = `shft_data` ? 3 : 1 and clear the unit count.
- **ON.** `key_out`=1. Each `tick` increments the 2-bit unit count. On the tick where the count reaches `dur`:
  - assert `shft_cnt`;
  - if `cntr_data`==1, go to CGAP;
  - else go to EGAP.
- **EGAP.** `key_out`=0. The shifted bit is valid here. On `tick`: latch `dur` from `shft_data` and go to ON.
- **CGAP.** `key_out`=0 for 3 ticks. On the third tick go to IDLE.
- **SPACE.** `key_out`=0. Each `tick` asserts `shft_cnt` (the code register counts down). On the tick where `cntr_data`==1, go to IDLE. This gives 7 units.
- **Invalid lengths.** `charlen_data` 9..15 is not checked. The elements beyond bit 7 come out as dots (shifted-in zeros).
- **Flow control.** `char_valid` outside IDLE is ignored; the source holds the character until `char_ready`.

## Timing
- **Reset.** While `reset`=1: `char_ready`, `char_load`, `shft_cnt`, `key_out` and `busy` are all 0; state becomes IDLE and the unit timer becomes 0. `char_ready`=1 in the first cycle after release.
- **Reset mid-character.** Aborts immediately: `key_out` is 0 in the reset cycle. No partial element resumes.
- **Output decode.** All outputs are combinational from state, `tick` and the inputs, with no added latency. `char_load` is combinational on `char_valid` in IDLE.
- **Element lengths.** `key_out` is high for exactly `dur`×UNIT_CYCLES cycles, starting the cycle after the aligning/gap tick. Element gaps are exactly UNIT_CYCLES cycles; character gaps exactly 3×UNIT_CYCLES.
- **Load-to-key latency.** From `char_load` to the first `key_out`: 2 cycles + wait to next tick + 1.
- **Coincident tick and shift.** When `tick` and `shft_cnt` coincide, `cntr_data` updates the following cycle. Decisions always use the pre-shift value.

## Structure
- **Package `morse_pkg`.** State enum {IDLE, LOAD, ALIGN, ON, EGAP, CGAP, SPACE}. Constants DOT_UNITS=1, DASH_UNITS=3, EGAP_UNITS=1, CGAP_UNITS=3, SPACE_LOAD=4'd7.
- **Sub-module `unit_timer`.** Parameterised by UNIT_CYCLES, outputs `tick`, uses synchronous reset. The controller FSM stays in `morse_ctrl`.

## Test plan (UNIT_CYCLES=4, bench includes the code register)
- **Reset.** Hold reset 3 cycles with `char_valid`=1 → all outputs 0, no `char_load`; `char_ready`=1 the cycle after release.
- **'E'.** Code 8'b0000_0000, len 1 → `key_out` high 4 cycles, then low 12 cycles, then `char_ready`=1; exactly one `shft_cnt`.
- **'A'.** Code 8'b0100_0000, len 2 → `key_out` high 4, low 4, high 12, low 12; `shft_cnt` twice.
- **Space.** len 0 → `key_out` 0 throughout, 7 `shft_cnt` pulses 4 cycles apart, IDLE after the 7th tick.
- **Back-to-back 'O','S'.** Codes 1110_0000/3 and 0000_0000/3, `char_valid` held → second `char_load` in the first IDLE cycle; key pattern is dash×3, gap 12 + align, dot×3.
- **Reset mid-dash.** Assert reset on the 6th cycle of a dash → `key_out` 0 that cycle, IDLE after; the next 'E' is timed exactly as in the 'E' scenario.
